etherneco_synctimer_slave: RTL
==============================

Name: etherneco_synctimer_slave

Overview:
- Slave-node end of the EtherNeco time-sync protocol. Pairs with the synctimer master that issues sync-time command packets (type 8'h10).
- Keeps a local free-running timer. Parses the master time from the command payload and either reloads the timer (renew) or nudges it by a low-pass-filtered offset (correct).
- Stamps its own arrival time into its per-node slot through the packet parser's replace path.
- Sits between the slave's outer-ring packet parser (header/payload strobes in, replace data out) and local time consumers.

Parameters:
TIMER_WIDTH, 64, local timer width (≥32)
STEP, 8, timer increment per clk
OFFSET_WIDTH, 24, signed saturated offset width
LPF_GAIN, 4, correction = offset >>> LPF_GAIN (arithmetic)
SYNC_TYPE, 8'h10, packet type handled
LATENCY_COMP, 0, constant added to received master time (TIMER_WIDTH bits)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
current_time  out  TIMER_WIDTH  local synchronized time
adjust_offset  out  OFFSET_WIDTH  signed offset of last correct
adjust_valid  out  1  one-cycle strobe with adjust_offset
rx_start  in  1  packet header accepted
rx_end  in  1  packet finished (one cycle)
rx_error  in  1  qualifies rx_end: CRC/format error
rx_length  in  16  payload length-1 (informational)
rx_type  in  8  packet type, stable rx_start..rx_end
rx_node  in  8  this node's index, stable rx_start..rx_end
payload_first  in  1  first payload byte
payload_last  in  1  last payload byte
payload_pos  in  16  byte index in payload
payload_data  in  8  payload byte
payload_valid  in  1  payload byte strobe
replace_data  out  8  substitute byte
replace_valid  out  1  use replace_data for this byte

Behaviour:
- Reset values: current_time=0, adjust_offset=0, adjust_valid=0, FSM=IDLE, flags/master_time/rx_time=0.
- Timer: current_time += STEP every cycle (modulo 2^TIMER_WIDTH) unless overridden below.
- FSM states: IDLE, RECV, APPLY.
  - IDLE: rx_start & rx_type==SYNC_TYPE → RECV. Latch rx_time=current_time (value in rx_start cycle) and clear got_len.
  - rx_start with another type: stay IDLE, ignore.
- Payload layout, little-endian:
  - pos 0: flags (bit0 correct, bit1 renew).
  - pos 1..8: master_time bytes 0..7.
  - pos 9+4*rx_node .. 12+4*rx_node: this node's stamp slot.
- RECV: each payload_valid at pos 0..8 is captured into flags/master_time. A byte at pos 8 sets got_len.
- RECV on rx_end:
  - rx_error=1 or got_len=0 → IDLE, no update.
  - Otherwise → APPLY.
- RECV on rx_start (restart): re-latch rx_time, clear got_len, stay RECV.
- APPLY (one cycle), with m = master_time + LATENCY_COMP:
  - renew=1 (priority over correct): current_time <= m. No adjust_valid.
  - renew=0, correct=1: off = m - rx_time (TIMER_WIDTH wrap, signed), saturated to ±(2^(OFFSET_WIDTH-1)-1 / -2^(OFFSET_WIDTH-1)).
    - adjust_offset <= off; adjust_valid=1 in the following cycle.
    - In that same cycle current_time += STEP + sign-extended (off >>> LPF_GAIN).
  - Neither flag set: no change.
  - APPLY → IDLE.
- Replace path (combinational, zero latency):
  - replace_valid = payload_valid & FSM==RECV & payload_pos in [9+4*rx_node, 12+4*rx_node].
  - replace_data = rx_time[8*(payload_pos-slot_base)+:8] (low 32 bits of rx_time).
  - Otherwise replace_valid=0, replace_data=0.
  - Slot arithmetic is 16-bit. If 12+4*rx_node overflows 16 bits, no replace.
- Payload bytes outside RECV are ignored. payload_valid without a preceding rx_start has no effect.
- Reset mid-packet: return to IDLE, discard partial capture, no adjust, timer reset to 0.
- A packet ending while in APPLY cannot occur (APPLY is one cycle; the parser's minimum gap is ≥1).

Test Plan:
- Reset, run 10 cycles → current_time = 0, 8, 16, …, 72; adjust_valid never asserted.
- Renew: type 0x10, flags=0x02, master_time=0x1000, clean rx_end → cycle after APPLY current_time=0x1000, then 0x1008; adjust_valid=0.
- Correct: rx_time=0x100 at rx_start, flags=0x01, master_time=0x200 → adjust_offset=0x000100, adjust_valid one cycle; timer advances 8+16=24 that cycle.
- Saturation: master_time=rx_time+0x4000_0000 with correct → adjust_offset=0x7FFFFF. master_time=rx_time-0x4000_0000 → 0x800000.
- Replace: rx_node=2, rx_time=0x11223344, payload pos 17..20 → replace_valid=1 with 0x44,0x33,0x22,0x11. Pos 16 and 21 → replace_valid=0.
- Rejects:
  - rx_error=1 at rx_end → no timer load, no adjust_valid.
  - type 0x20 → no replace, no capture.
  - rx_end after only pos 0..5 → discarded.

Source files
------------

// File: rtl/etherneco_synctimer_slave_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : etherneco_synctimer_slave_if                               |
// | Brief   : Packet-parser <-> synctimer slave bus (rx, payload, replace)|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface etherneco_synctimer_slave_if;
    logic        rx_start;
    logic        rx_end;
    logic        rx_error;
    logic [15:0] rx_length;
    logic [7:0]  rx_type;
    logic [7:0]  rx_node;
    logic        payload_first;
    logic        payload_last;
    logic [15:0] payload_pos;
    logic [7:0]  payload_data;
    logic        payload_valid;
    logic [7:0]  replace_data;
    logic        replace_valid;

    modport master (
        output rx_start, rx_end, rx_error, rx_length, rx_type, rx_node,
               payload_first, payload_last, payload_pos, payload_data, payload_valid,
        input  replace_data, replace_valid
    );

    modport slave (
        input  rx_start, rx_end, rx_error, rx_length, rx_type, rx_node,
               payload_first, payload_last, payload_pos, payload_data, payload_valid,
        output replace_data, replace_valid
    );
endinterface
`default_nettype wire

// File: rtl/etherneco_synctimer_slave.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : etherneco_synctimer_slave                                  |
// | Brief   : Slave-side time sync: local timer, renew/correct, stamping |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module etherneco_synctimer_slave #(
    parameter int                     TIMER_WIDTH  = 64,
    parameter int                     STEP         = 8,
    parameter int                     OFFSET_WIDTH = 24,
    parameter int                     LPF_GAIN     = 4,
    parameter logic [7:0]             SYNC_TYPE    = 8'h10,
    parameter logic [TIMER_WIDTH-1:0] LATENCY_COMP = '0
) (
    input  wire logic                    clk,
    input  wire logic                    reset,
    output logic [TIMER_WIDTH-1:0]       current_time,
    output logic [OFFSET_WIDTH-1:0]      adjust_offset,
    output logic                         adjust_valid,
    etherneco_synctimer_slave_if.slave   bus
);
    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_RECV  = 2'd1;
    localparam logic [1:0] c_APPLY = 2'd2;

    localparam logic signed [TIMER_WIDTH-1:0] c_OFF_MAX =
        $signed((TIMER_WIDTH'(1) << (OFFSET_WIDTH-1)) - TIMER_WIDTH'(1));
    localparam logic signed [TIMER_WIDTH-1:0] c_OFF_MIN = ~c_OFF_MAX;

    logic [1:0]              state_q, state_d;
    logic [TIMER_WIDTH-1:0]  current_time_q, current_time_d;
    logic [TIMER_WIDTH-1:0]  rx_time_q, rx_time_d;
    logic [63:0]             master_time_q, master_time_d;
    logic [7:0]              flags_q, flags_d;
    logic                    got_len_q, got_len_d;
    logic [OFFSET_WIDTH-1:0] adjust_offset_q, adjust_offset_d;
    logic                    adjust_valid_q, adjust_valid_d;

    logic [TIMER_WIDTH-1:0]         m_time;
    logic signed [TIMER_WIDTH-1:0]  diff_s;
    logic [OFFSET_WIDTH-1:0]        off_sat;
    logic signed [OFFSET_WIDTH-1:0] off_shift;
    logic [TIMER_WIDTH-1:0]         corr;
    logic [2:0]                     byte_idx;
    logic [16:0]                    slot_base, slot_end, pos_ext;
    logic [1:0]                     slot_idx;
    logic                           in_slot;
    logic                           unused_inputs;

    assign unused_inputs = ^{bus.rx_length, bus.payload_first, bus.payload_last};

    // Offset is the wrapped difference interpreted as signed, then clamped.
    assign m_time    = TIMER_WIDTH'(master_time_q) + LATENCY_COMP;
    assign diff_s    = $signed(m_time - rx_time_q);
    assign off_shift = $signed(off_sat) >>> LPF_GAIN;
    assign corr      = {{(TIMER_WIDTH-OFFSET_WIDTH){off_shift[OFFSET_WIDTH-1]}}, off_shift};
    assign byte_idx  = bus.payload_pos[2:0] - 3'd1;

    always_comb begin
        off_sat = diff_s[OFFSET_WIDTH-1:0];
        if (diff_s > c_OFF_MAX) begin
            off_sat = c_OFF_MAX[OFFSET_WIDTH-1:0];
        end else if (diff_s < c_OFF_MIN) begin
            off_sat = c_OFF_MIN[OFFSET_WIDTH-1:0];
        end
    end

    always_comb begin
        state_d         = state_q;
        current_time_d  = current_time_q + TIMER_WIDTH'(STEP);
        rx_time_d       = rx_time_q;
        master_time_d   = master_time_q;
        flags_d         = flags_q;
        got_len_d       = got_len_q;
        adjust_offset_d = adjust_offset_q;
        adjust_valid_d  = 1'b0;
        case (state_q)
            c_IDLE: begin
                if (bus.rx_start && (bus.rx_type == SYNC_TYPE)) begin
                    state_d   = c_RECV;
                    rx_time_d = current_time_q;
                    got_len_d = 1'b0;
                end
            end
            c_RECV: begin
                if (bus.payload_valid && (bus.payload_pos <= 16'd8)) begin
                    if (bus.payload_pos == 16'd0) begin
                        flags_d = bus.payload_data;
                    end else begin
                        master_time_d[{byte_idx, 3'b000} +: 8] = bus.payload_data;
                    end
                    if (bus.payload_pos == 16'd8) begin
                        got_len_d = 1'b1;
                    end
                end
                if (bus.rx_end) begin
                    state_d = (!bus.rx_error && got_len_q) ? c_APPLY : c_IDLE;
                end else if (bus.rx_start) begin
                    rx_time_d = current_time_q;
                    got_len_d = 1'b0;
                end
            end
            c_APPLY: begin
                state_d = c_IDLE;
                if (flags_q[1]) begin
                    current_time_d = m_time;
                end else if (flags_q[0]) begin
                    adjust_offset_d = off_sat;
                    adjust_valid_d  = 1'b1;
                    current_time_d  = current_time_q + TIMER_WIDTH'(STEP) + corr;
                end
            end
            default: state_d = c_IDLE;
        endcase
    end

    // Per-node stamp slot; a slot that would run past 16 bits is never replaced.
    always_comb begin
        slot_base = 17'd9 + {7'd0, bus.rx_node, 2'b00};
        slot_end  = slot_base + 17'd3;
        pos_ext   = {1'b0, bus.payload_pos};
        slot_idx  = bus.payload_pos[1:0] - slot_base[1:0];
        in_slot   = !slot_end[16] && (pos_ext >= slot_base) && (pos_ext <= slot_end);
        bus.replace_valid = 1'b0;
        bus.replace_data  = 8'h00;
        if (bus.payload_valid && (state_q == c_RECV) && in_slot) begin
            bus.replace_valid = 1'b1;
            bus.replace_data  = rx_time_q[{slot_idx, 3'b000} +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= c_IDLE;
            current_time_q  <= '0;
            rx_time_q       <= '0;
            master_time_q   <= '0;
            flags_q         <= '0;
            got_len_q       <= 1'b0;
            adjust_offset_q <= '0;
            adjust_valid_q  <= 1'b0;
        end else begin
            state_q         <= state_d;
            current_time_q  <= current_time_d;
            rx_time_q       <= rx_time_d;
            master_time_q   <= master_time_d;
            flags_q         <= flags_d;
            got_len_q       <= got_len_d;
            adjust_offset_q <= adjust_offset_d;
            adjust_valid_q  <= adjust_valid_d;
        end
    end

    assign current_time  = current_time_q;
    assign adjust_offset = adjust_offset_q;
    assign adjust_valid  = adjust_valid_q;
endmodule
`default_nettype wire
